// File: rtl/vector_addsub_serial_in.sv
// Serial-in vector adder/subtractor: gathers N-element A/B vectors LANES per beat, emits S = A +/- B in parallel.
// Optional clamping to the IN_WIDTH signed range is enabled with `define VECADD_SATURATE_EN.
module vector_addsub_serial_in #(
   parameter int IN_WIDTH = 10,
   parameter int N        = 10,
   parameter int LANES    = 2,
   parameter int CNT_W    = $clog2(N / LANES) + 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      enable,
   output logic                      readyForNewDataSeries,
   input  logic                      inReady,
   input  logic                      subMode,
   input  logic [LANES*IN_WIDTH-1:0] A_in,
   input  logic [LANES*IN_WIDTH-1:0] B_in,
   output logic [N*(IN_WIDTH+1)-1:0] S,
   output logic                      outReady,
   output logic                      earlyOutReady,
   output logic                      overflow
);
   localparam int OW    = IN_WIDTH + 1;
   localparam int BEATS = N / LANES;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

   if ((LANES < 1) || (LANES > N) || ((N % LANES) != 0)) begin : g_cfg_check
      $error("vector_addsub_serial_in: N must be a positive multiple of LANES");
   end

   typedef enum logic [1:0] {IDLE, LOAD, ISSUE} state_t;

   state_t                  state, state_nxt;
   logic [CNT_W-1:0]        cnt_p0, cnt_nxt, beat_idx;
   logic [N*IN_WIDTH-1:0]   a_p0, b_p0;
   logic                    sub_p0;
   logic [N*OW-1:0]         res_c;
   logic [N*OW-1:0]         s_p1;
   logic                    vld_p1;

   function automatic logic signed [OW-1:0] add_sub(input logic signed [IN_WIDTH-1:0] a,
                                                    input logic signed [IN_WIDTH-1:0] b,
                                                    input logic sub);
      logic signed [OW-1:0] ax, bx;
      ax = {a[IN_WIDTH-1], a};
      bx = {b[IN_WIDTH-1], b};
      return sub ? (ax - bx) : (ax + bx);
   endfunction

`ifdef VECADD_SATURATE_EN
   localparam logic signed [OW-1:0] SAT_MAX = {2'b00, {(IN_WIDTH-1){1'b1}}};
   localparam logic signed [OW-1:0] SAT_MIN = {2'b11, {(IN_WIDTH-1){1'b0}}};

   logic ovf_c, ovf_p1;

   function automatic logic signed [OW-1:0] saturate(input logic signed [OW-1:0] v);
      if (v > SAT_MAX) return SAT_MAX;
      if (v < SAT_MIN) return SAT_MIN;
      return v;
   endfunction
`endif

   // Beat 0 is taken in IDLE and in ISSUE (series overlap); later beats only in LOAD.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt_p0;
      case (state)
         IDLE, ISSUE: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            if (inReady) begin
               if (BEATS == 1) begin
                  state_nxt = ISSUE;
               end else begin
                  state_nxt = LOAD;
                  cnt_nxt   = CNT_W'(1);
               end
            end
         end
         LOAD: begin
            if (inReady) begin
               if (cnt_p0 == LAST_BEAT) begin
                  state_nxt = ISSUE;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt_p0 + CNT_W'(1);
               end
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= IDLE;
         cnt_p0 <= '0;
      end else if (enable) begin
         state  <= state_nxt;
         cnt_p0 <= cnt_nxt;
      end
   end

   assign beat_idx = (state == LOAD) ? cnt_p0 : '0;

   // Stage p0: capture registers filled beat by beat
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         a_p0   <= '0;
         b_p0   <= '0;
         sub_p0 <= 1'b0;
      end else if (enable && inReady) begin
         if (state != LOAD) sub_p0 <= subMode;
         for (int k = 0; k < N; k++) begin
            if ((k / LANES) == int'(beat_idx)) begin
               a_p0[k*IN_WIDTH +: IN_WIDTH] <= A_in[(k % LANES)*IN_WIDTH +: IN_WIDTH];
               b_p0[k*IN_WIDTH +: IN_WIDTH] <= B_in[(k % LANES)*IN_WIDTH +: IN_WIDTH];
            end
         end
      end
   end

   always_comb begin
      res_c = '0;
`ifdef VECADD_SATURATE_EN
      ovf_c = 1'b0;
`endif
      for (int k = 0; k < N; k++) begin
`ifdef VECADD_SATURATE_EN
         res_c[k*OW +: OW] = saturate(add_sub(a_p0[k*IN_WIDTH +: IN_WIDTH],
                                              b_p0[k*IN_WIDTH +: IN_WIDTH], sub_p0));
         if (res_c[k*OW +: OW] != add_sub(a_p0[k*IN_WIDTH +: IN_WIDTH],
                                          b_p0[k*IN_WIDTH +: IN_WIDTH], sub_p0))
            ovf_c = 1'b1;
`else
         res_c[k*OW +: OW] = add_sub(a_p0[k*IN_WIDTH +: IN_WIDTH],
                                     b_p0[k*IN_WIDTH +: IN_WIDTH], sub_p0);
`endif
      end
   end

   // Stage p1: result register, loaded only at the end of ISSUE and held otherwise
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s_p1   <= '0;
         vld_p1 <= 1'b0;
`ifdef VECADD_SATURATE_EN
         ovf_p1 <= 1'b0;
`endif
      end else if (enable) begin
         vld_p1 <= (state == ISSUE);
         if (state == ISSUE) begin
            s_p1 <= res_c;
`ifdef VECADD_SATURATE_EN
            ovf_p1 <= ovf_c;
`endif
         end
      end
   end

   assign S                     = s_p1;
   assign outReady              = vld_p1;
   assign earlyOutReady         = (state == ISSUE);
   assign readyForNewDataSeries = (state != LOAD);
`ifdef VECADD_SATURATE_EN
   assign overflow = ovf_p1;
`else
   assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_vector_addsub_serial_in.sv
// Self-checking bench for vector_addsub_serial_in: directed scenarios plus randomized series
// compared cycle by cycle against a beat-counting reference model.
module tb_vector_addsub_serial_in;
   localparam int IN_WIDTH = 10;
   localparam int N        = 10;
   localparam int LANES    = 2;
   localparam int BEATS    = N / LANES;
   localparam int OW       = IN_WIDTH + 1;
   localparam int SW       = N * OW;
   localparam int MAXV     = (1 << (IN_WIDTH - 1)) - 1;
   localparam int MINV     = -(1 << (IN_WIDTH - 1));

   logic                      clk = 1'b0;
   logic                      reset, enable, inReady, subMode;
   logic [LANES*IN_WIDTH-1:0] A_in, B_in;
   logic [SW-1:0]             S;
   logic                      readyForNewDataSeries, outReady, earlyOutReady, overflow;

   int checks = 0;
   int errors = 0;

   int drv_a [N];
   int drv_b [N];

   // reference model state
   int            m_a [N];
   int            m_b [N];
   int            m_beat = 0;
   bit            m_sub = 1'b0, m_early = 1'b0, m_out = 1'b0, m_ovf = 1'b0, p_ovf = 1'b0;
   logic [SW-1:0] m_S = '0, p_S = '0;

   vector_addsub_serial_in #(.IN_WIDTH(IN_WIDTH), .N(N), .LANES(LANES)) dut (
      .clk                   (clk),
      .reset                 (reset),
      .enable                (enable),
      .readyForNewDataSeries (readyForNewDataSeries),
      .inReady               (inReady),
      .subMode               (subMode),
      .A_in                  (A_in),
      .B_in                  (B_in),
      .S                     (S),
      .outReady              (outReady),
      .earlyOutReady         (earlyOutReady),
      .overflow              (overflow)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [SW-1:0] got, input logic [SW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic model_compute();
      int r;
      bit o;
      o = 1'b0;
      for (int k = 0; k < N; k++) begin
         r = m_sub ? (m_a[k] - m_b[k]) : (m_a[k] + m_b[k]);
`ifdef VECADD_SATURATE_EN
         if (r > MAXV) begin r = MAXV; o = 1'b1; end
         else if (r < MINV) begin r = MINV; o = 1'b1; end
`endif
         p_S[k*OW +: OW] = r[OW-1:0];
      end
      p_ovf = o;
   endtask

   // Model: every enabled inReady is one beat; the series result appears one enabled
   // cycle after the last beat as earlyOutReady, and one more later on S/outReady.
   initial begin
      forever begin
         @(posedge clk or negedge reset);
         if (!reset) begin
            m_beat = 0; m_early = 1'b0; m_out = 1'b0; m_S = '0; m_ovf = 1'b0;
         end else begin
            if (enable) begin
               m_out = m_early;
               if (m_early) begin m_S = p_S; m_ovf = p_ovf; end
               m_early = 1'b0;
               if (inReady) begin
                  if (m_beat == 0) m_sub = subMode;
                  for (int l = 0; l < LANES; l++) begin
                     m_a[m_beat*LANES+l] = $signed(A_in[l*IN_WIDTH +: IN_WIDTH]);
                     m_b[m_beat*LANES+l] = $signed(B_in[l*IN_WIDTH +: IN_WIDTH]);
                  end
                  m_beat++;
                  if (m_beat == BEATS) begin
                     m_beat = 0;
                     model_compute();
                     m_early = 1'b1;
                  end
               end
            end
            #1;
            if (reset) begin
               check_val("S", S, m_S);
               check_val("outReady", SW'(outReady), SW'(m_out));
               check_val("earlyOutReady", SW'(earlyOutReady), SW'(m_early));
               check_val("ready", SW'(readyForNewDataSeries), SW'(m_beat == 0));
               check_val("overflow", SW'(overflow), SW'(m_ovf));
            end
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_beat(input int j);
      for (int l = 0; l < LANES; l++) begin
         A_in[l*IN_WIDTH +: IN_WIDTH] = drv_a[j*LANES+l][IN_WIDTH-1:0];
         B_in[l*IN_WIDTH +: IN_WIDTH] = drv_b[j*LANES+l][IN_WIDTH-1:0];
      end
   endtask

   // subMode is inverted on every beat after beat 0 so mode sampling is always exercised.
   task automatic drive_series(input bit sub, input int gap, input bit rnd, input int stall_beat,
                               input int nbeats);
      int g;
      for (int j = 0; j < nbeats; j++) begin
         if (j > 0) begin
            g = rnd ? int'($urandom_range(gap, 0)) : gap;
            repeat (g) begin
               inReady = 1'b0;
               enable  = rnd ? ($urandom_range(3, 0) != 0) : 1'b1;
               subMode = 1'($urandom);
               A_in    = LANES*IN_WIDTH'($urandom);
               cyc();
            end
         end
         set_beat(j);
         subMode = (j == 0) ? sub : ~sub;
         if (j == stall_beat) begin
            enable  = 1'b0;
            inReady = 1'b1;
            repeat (3) cyc();
         end
         enable  = 1'b1;
         inReady = 1'b1;
         cyc();
         inReady = 1'b0;
      end
   endtask

   task automatic wait_out(input string tag);
      int i;
      i = 0;
      while (!outReady && i < 40) begin
         cyc();
         i++;
      end
      check_val({tag, "_outReady_seen"}, SW'(outReady), SW'(1));
   endtask

   task automatic apply_reset_checked();
      @(posedge clk);
      #3;
      reset = 1'b0;
      #1;
      check_val("rst_S", S, '0);
      check_val("rst_outReady", SW'(outReady), '0);
      check_val("rst_earlyOutReady", SW'(earlyOutReady), '0);
      check_val("rst_overflow", SW'(overflow), '0);
      check_val("rst_ready", SW'(readyForNewDataSeries), SW'(1));
      repeat (2) @(posedge clk);
      #3;
      reset = 1'b1;
      cyc();
   endtask

   task automatic load_ramp();
      for (int k = 0; k < N; k++) begin
         drv_a[k] = k;
         drv_b[k] = 10;
      end
   endtask

   function automatic logic [SW-1:0] expect_offset(input int off);
      logic [SW-1:0] e;
      e = '0;
      for (int k = 0; k < N; k++) e[k*OW +: OW] = OW'(k + off);
      return e;
   endfunction

   function automatic logic [SW-1:0] expect_all(input int v);
      logic [SW-1:0] e;
      e = '0;
      for (int k = 0; k < N; k++) e[k*OW +: OW] = OW'(v);
      return e;
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; enable = 1'b0; inReady = 1'b0; subMode = 1'b0; A_in = '0; B_in = '0;
      #2 reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_val("init_S", S, '0);
      check_val("init_outReady", SW'(outReady), '0);
      check_val("init_earlyOutReady", SW'(earlyOutReady), '0);
      check_val("init_overflow", SW'(overflow), '0);
      check_val("init_ready", SW'(readyForNewDataSeries), SW'(1));
      @(posedge clk);
      #3 reset = 1'b1;
      enable = 1'b1;
      cyc();

      // add ramp + 10
      load_ramp();
      drive_series(1'b0, 0, 1'b0, -1, BEATS);
      check_val("t1_early", SW'(earlyOutReady), SW'(1));
      wait_out("t1");
      check_val("t1_S", S, expect_offset(10));
      check_val("t1_overflow", SW'(overflow), '0);
      repeat (2) cyc();

      // 511 - (-512)
      for (int k = 0; k < N; k++) begin drv_a[k] = MAXV; drv_b[k] = MINV; end
      drive_series(1'b1, 0, 1'b0, -1, BEATS);
      wait_out("t2");
`ifdef VECADD_SATURATE_EN
      check_val("t2_S", S, expect_all(MAXV));
      check_val("t2_overflow", SW'(overflow), SW'(1));
`else
      check_val("t2_S", S, expect_all(1023));
      check_val("t2_overflow", SW'(overflow), '0);
`endif
      repeat (2) cyc();

      // 2-cycle gaps plus a 3-cycle enable stall mid-series
      load_ramp();
      drive_series(1'b0, 2, 1'b0, 2, BEATS);
      wait_out("t3");
      check_val("t3_S", S, expect_offset(10));
      repeat (3) cyc();

      // back-to-back: second series (subtract, A == B) starts in the ISSUE cycle
      load_ramp();
      drive_series(1'b0, 0, 1'b0, -1, BEATS);
      for (int k = 0; k < N; k++) begin
         drv_a[k] = int'($urandom_range(1023, 0)) - 512;
         drv_b[k] = drv_a[k];
      end
      drive_series(1'b1, 0, 1'b0, -1, 3);
      check_val("t4_first_held", S, expect_offset(10));
      drive_series(1'b1, 0, 1'b0, -1, BEATS - 3);
      wait_out("t4");
      check_val("t4_S", S, '0);
      repeat (2) cyc();

      // reset after beat 3 discards the partial series
      load_ramp();
      drive_series(1'b0, 0, 1'b0, -1, 4);
      apply_reset_checked();
      repeat (8) cyc();
      check_val("t5_no_pulse_S", S, '0);
      drive_series(1'b0, 0, 1'b0, -1, BEATS);
      wait_out("t5");
      check_val("t5_S", S, expect_offset(10));
      repeat (2) cyc();

      // subtract sampled at beat 0 while subMode toggles on later beats
      load_ramp();
      drive_series(1'b1, 1, 1'b0, -1, BEATS);
      wait_out("t6");
      check_val("t6_S", S, expect_offset(-10));
      repeat (2) cyc();

      // randomized series with gaps, enable drops and overlap
      for (int s = 0; s < 40; s++) begin
         for (int k = 0; k < N; k++) begin
            case ($urandom_range(3, 0))
               0: drv_a[k] = MAXV;
               1: drv_a[k] = MINV;
               default: drv_a[k] = int'($urandom_range(1023, 0)) - 512;
            endcase
            case ($urandom_range(3, 0))
               0: drv_b[k] = MAXV;
               1: drv_b[k] = MINV;
               default: drv_b[k] = int'($urandom_range(1023, 0)) - 512;
            endcase
         end
         drive_series(1'($urandom), 2, 1'b1, ($urandom_range(3, 0) == 0) ? 1 : -1, BEATS);
         enable = 1'b1;
         repeat ($urandom_range(2, 0)) cyc();
      end
      repeat (6) cyc();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
